// File: rtl/tick_sched_pkg.sv
// tick_scheduler shared types: command ops, channel states
// and prescaler sizing helpers.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    OP_STOP     = 2'd0,
    OP_ONESHOT  = 2'd1,
    OP_PERIODIC = 2'd2,
    OP_RSVD     = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_ONE = 2'd1,
    RUN_PER = 2'd2
  } ch_state_e;

  function automatic int calc_div(
    input int clk_hz,
    input int tick_hz
  );
    return clk_hz / tick_hz;
  endfunction

  function automatic int calc_cnt_w(
    input int clk_hz,
    input int tick_hz
  );
    int d;
    d = calc_div(clk_hz, tick_hz);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/tick_scheduler_channel.sv
// One timer channel: counts base-tick strobes down from a
// loaded period and pulses tick on expiry.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                clk_fpga,
  input  logic                rst_n,
  input  logic                str,
  input  logic                load,
  input  logic                stop,
  input  op_e                 op,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick,
  output logic                active
);

  ch_state_e           state_q, state_d;
  logic [PERIOD_W-1:0] rem_q, rem_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic                tick_q, tick_d;

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      per_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      per_q   <= per_d;
      tick_q  <= tick_d;
    end
  end

  // load/stop never coincide with str: the port is not ready on str
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    per_d   = per_q;
    tick_d  = 1'b0;
    unique case (1'b1)
      load: begin
        per_d   = period;
        rem_d   = period;
        state_d = (op == OP_PERIODIC) ? RUN_PER : RUN_ONE;
      end
      stop: begin
        state_d = IDLE;
        rem_d   = '0;
      end
      (str && state_q != IDLE): begin
        if (rem_q == PERIOD_W'(1)) begin
          tick_d = 1'b1;
          if (state_q == RUN_PER) begin
            rem_d = per_q;
          end else begin
            state_d = IDLE;
            rem_d   = '0;
          end
        end else begin
          rem_d = rem_q - PERIOD_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign tick   = tick_q;
  assign active = (state_q != IDLE);

endmodule

// File: rtl/tick_scheduler.sv
// Shared 1 ms-style time base: one prescaler feeding
// NUM_CH command-configured timer channels.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_fpga,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_op,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic                base_tick,
  output logic [NUM_CH-1:0]   tick_out,
  output logic [NUM_CH-1:0]   ch_active
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int CNT_W = calc_cnt_w(CLK_HZ, TICK_HZ);

  logic [CNT_W-1:0] cnt_q;
  logic             str;
  logic             base_q;

  assign str = (cnt_q == CNT_W'(DIV - 1));

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      base_q <= 1'b0;
    end else begin
      cnt_q  <= str ? '0 : cnt_q + CNT_W'(1);
      base_q <= str;
    end
  end

  assign base_tick = base_q;
  assign cfg_ready = !str;

  logic accept;
  op_e  cmd_op;
  logic cmd_run;

  assign accept  = cfg_valid && cfg_ready;
  assign cmd_op  = op_e'(cfg_op);
  // zero period and the reserved op both fall back to STOP
  assign cmd_run = ((cmd_op == OP_ONESHOT) ||
                    (cmd_op == OP_PERIODIC)) &&
                   (cfg_period != '0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = accept && (cfg_ch == CH_W'(i));

    tick_channel #(
      .PERIOD_W(PERIOD_W)
    ) u_ch (
      .clk_fpga(clk_fpga),
      .rst_n   (rst_n),
      .str     (str),
      .load    (sel && cmd_run),
      .stop    (sel && !cmd_run),
      .op      (cmd_op),
      .period  (cfg_period),
      .tick    (tick_out[i]),
      .active  (ch_active[i])
    );
  end

endmodule
